fpu_issue: RTL

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_issue_if.sv | 45 ++++
 rtl/fpu_issue.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fpu_issue_if.sv
// Request, response and FPU-side signal bundle for fpu_issue.
// slave = issue controller view, master = CPU/FPU/testbench view.
interface fpu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_x1;
  logic [4:0]  req_x2;
  logic [4:0]  req_y;
  logic [31:0] req_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data32;
  logic        rsp_flag;
  logic        rsp_err;

  logic [5:0]  fpu_operation;
  logic [4:0]  fpu_x1;
  logic [4:0]  fpu_x2;
  logic [4:0]  fpu_y;
  logic [31:0] fpu_in_data;
  logic        fpu_ready;
  logic        fpu_valid;
  logic        fpu_out_data1;
  logic [31:0] fpu_out_data32;

  modport slave (
    input  req_valid, req_op, req_x1, req_x2, req_y, req_data,
    output req_ready,
    output rsp_valid, rsp_data32, rsp_flag, rsp_err,
    input  rsp_ready,
    output fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data, fpu_ready,
    input  fpu_valid, fpu_out_data1, fpu_out_data32
  );

  modport master (
    output req_valid, req_op, req_x1, req_x2, req_y, req_data,
    input  req_ready,
    input  rsp_valid, rsp_data32, rsp_flag, rsp_err,
    output rsp_ready,
    input  fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data, fpu_ready,
    output fpu_valid, fpu_out_data1, fpu_out_data32
  );
endinterface

// File: rtl/fpu_issue.sv
// Single-outstanding FPU issue controller: latches a CPU request, drives the FPU, returns a completion record.
// Optional WAITV abort timer enabled by defining FPU_ISSUE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | one-cycle fpu_ready strobe
// WAITV | waiting for fpu_valid
// DRAIN | one cycle for FPU register write-back
// RESP  | completion record held until rsp_ready
module fpu_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  fpu_issue_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAITV, DRAIN, RESP} state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [4:0]  x1_q, x2_q, y_q;
  logic [31:0] data_q;
  logic [31:0] rsp_data_q;
  logic        rsp_flag_q, rsp_err_q;
  logic        legal_op, imm_op, tmo_hit, fpu_hit;
  logic        req_ready_c, fpu_ready_c, rsp_valid_c;

  always_comb begin
    legal_op = 1'b0;
    case (bus.req_op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b100000,
      6'b111000, 6'b111001, 6'b111101, 6'b111110, 6'b111111: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  // Only legal opcodes reach ISSUE, so the held opcode alone decides the class.
  always_comb begin
    imm_op = 1'b0;
    case (op_q)
      6'b111101, 6'b111110, 6'b111111: imm_op = 1'b1;
      default: imm_op = 1'b0;
    endcase
  end

  assign fpu_hit = bus.fpu_valid && ((state_q == ISSUE) || (state_q == WAITV));

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tmo_cnt <= '0;
    else if (state_q == ISSUE) tmo_cnt <= '0;
    else if (state_q == WAITV) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state_q == WAITV) && !bus.fpu_valid &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    fpu_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_d = legal_op ? ISSUE : RESP;
      end
      ISSUE: begin
        fpu_ready_c = 1'b1;
        if (bus.fpu_valid) state_d = imm_op ? RESP : DRAIN;
        else               state_d = WAITV;
      end
      WAITV: begin
        if (bus.fpu_valid) state_d = DRAIN;
        else if (tmo_hit)  state_d = RESP;
      end
      DRAIN: state_d = RESP;
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      y_q        <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_flag_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && bus.req_valid) begin
        op_q       <= bus.req_op;
        x1_q       <= bus.req_x1;
        x2_q       <= bus.req_x2;
        y_q        <= bus.req_y;
        data_q     <= bus.req_data;
        rsp_data_q <= '0;
        rsp_flag_q <= 1'b0;
        rsp_err_q  <= !legal_op;
      end
      if (fpu_hit) begin
        rsp_data_q <= bus.fpu_out_data32;
        rsp_flag_q <= bus.fpu_out_data1;
      end
      if (tmo_hit) begin
        rsp_data_q <= '0;
        rsp_flag_q <= 1'b0;
        rsp_err_q  <= 1'b1;
      end
    end
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.fpu_ready     = fpu_ready_c;
  assign bus.rsp_valid     = rsp_valid_c;
  assign bus.rsp_data32    = rsp_data_q;
  assign bus.rsp_flag      = rsp_flag_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.fpu_operation = op_q;
  assign bus.fpu_x1        = x1_q;
  assign bus.fpu_x2        = x2_q;
  assign bus.fpu_y         = y_q;
  assign bus.fpu_in_data   = data_q;
endmodule
